// File: rtl/pipe_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
package pipe_pkg;

  localparam int ADDR_W = 3;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } stage_en_t;

endpackage

// File: rtl/pipe_fwd_unit.sv
// Operand forwarding select for one EX operand; latency: combinational.
// Backpressure: none, pure compare of source against in-flight destinations.
module pipe_fwd_unit
  import pipe_pkg::*;
#(
  parameter int ADDR_W = pipe_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] src_addr,
  input  logic              ex_wr_en,
  input  logic [ADDR_W-1:0] ex_write_addr,
  input  logic              mem_wr_en,
  input  logic [ADDR_W-1:0] mem_write_addr,
  output logic [1:0]        fwd_sel
);

  // The younger producer (EX_MEM) wins; r0 is hardwired and never forwards.
  always_comb begin
    fwd_sel = FWD_RF;
    if (src_addr != '0) begin
      if (ex_wr_en && (ex_write_addr == src_addr)) begin
        fwd_sel = FWD_EXMEM;
      end else if (mem_wr_en && (mem_write_addr == src_addr)) begin
        fwd_sel = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/sequencing controller: load-use stall, branch flush, data-memory wait; outputs combinational
// from state and inputs, memory backpressure via mem_req/mem_ready. Optional stall counter: PIPE_STALL_CNT_EN.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int ADDR_W      = pipe_pkg::ADDR_W,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic [ADDR_W-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_wr_en,
  input  logic              ex_load,
  input  logic [ADDR_W-1:0] ex_write_addr,
  input  logic              mem_wr_en,
  input  logic              mem_access,
  input  logic [ADDR_W-1:0] mem_write_addr,
  input  logic              mem_ready,
  input  logic              branch_taken,
  output logic              mem_req,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              mem_wb_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_err
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(MEM_TIMEOUT);

  if (MEM_TIMEOUT < 1 || CNT_W < 1) begin : g_param_chk
    $error("pipe_hazard_ctrl: MEM_TIMEOUT and CNT_W must be at least 1");
  end

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             mem_err_q, mem_err_d;
  stage_en_t        en;
  logic             mem_stall;
  logic             load_use;
  logic [1:0]       fwd_a_raw, fwd_b_raw;

  assign mem_stall = mem_access & ~mem_ready;

  assign load_use = ex_load & ex_wr_en & (ex_write_addr != '0) &
                    ((id_use_rs1 & (id_rs1 == ex_write_addr)) |
                     (id_use_rs2 & (id_rs2 == ex_write_addr)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      timer_q   <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Timer counts stall cycles of the current access, the RUN cycle that raised mem_req being cycle 0.
  always_comb begin
    state_d = state_q;
    timer_d = '0;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          timer_d = TMR_W'(1);
        end else if (branch_taken) begin
          state_d = RUN;
        end else if (load_use) begin
          state_d = LOAD_STALL;
        end
      end
      LOAD_STALL: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          timer_d = TMR_W'(1);
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d = RUN;
        end else begin
          timer_d = (timer_q == TMR_MAX) ? timer_q : timer_q + TMR_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
    mem_err_d = mem_err_q | ((state_d == MEM_WAIT) && (timer_d == TMR_MAX));
  end

  // Outputs are forced to their idle values while reset is held, independent of inputs.
  always_comb begin
    en          = '1;
    mem_req     = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (rst) begin
      case (state_q)
        RUN: begin
          if (mem_stall) begin
            en      = '0;
            mem_req = 1'b1;
          end else if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            en.pc       = 1'b0;
            en.if_id    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        LOAD_STALL: begin
          // The load now sits in MEM; its access still has to be honoured.
          if (mem_stall) begin
            en      = '0;
            mem_req = 1'b1;
          end
        end
        MEM_WAIT: begin
          mem_req = 1'b1;
          if (!mem_ready) begin
            en = '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign pc_en     = en.pc;
  assign if_id_en  = en.if_id;
  assign id_ex_en  = en.id_ex;
  assign ex_mem_en = en.ex_mem;
  assign mem_wb_en = en.mem_wb;
  assign mem_err   = mem_err_q;

  pipe_fwd_unit #(.ADDR_W(ADDR_W)) u_fwd_a (
    .src_addr       (id_rs1),
    .ex_wr_en       (ex_wr_en),
    .ex_write_addr  (ex_write_addr),
    .mem_wr_en      (mem_wr_en),
    .mem_write_addr (mem_write_addr),
    .fwd_sel        (fwd_a_raw)
  );

  pipe_fwd_unit #(.ADDR_W(ADDR_W)) u_fwd_b (
    .src_addr       (id_rs2),
    .ex_wr_en       (ex_wr_en),
    .ex_write_addr  (ex_write_addr),
    .mem_wr_en      (mem_wr_en),
    .mem_write_addr (mem_write_addr),
    .fwd_sel        (fwd_b_raw)
  );

  assign fwd_a = rst ? fwd_a_raw : FWD_RF;
  assign fwd_b = rst ? fwd_b_raw : FWD_RF;

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!en.pc && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a per-cycle behavioural model compare.
module tb_pipe_hazard_ctrl;

  localparam int AW      = 3;
  localparam int TIMEOUT = 15;
  localparam int CW      = 16;

  logic          clk;
  logic          rst;
  logic [AW-1:0] id_rs1, id_rs2;
  logic          id_use_rs1, id_use_rs2;
  logic          ex_wr_en, ex_load;
  logic [AW-1:0] ex_write_addr;
  logic          mem_wr_en, mem_access;
  logic [AW-1:0] mem_write_addr;
  logic          mem_ready, branch_taken;
  logic          mem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic          if_id_flush, id_ex_flush;
  logic [1:0]    fwd_a, fwd_b;
  logic          mem_err;
`ifdef PIPE_STALL_CNT_EN
  logic [CW-1:0] stall_cnt;
`endif

  int n_vec;
  int n_bad;
  int cyc;

  pipe_hazard_ctrl #(.ADDR_W(AW), .MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .ex_wr_en       (ex_wr_en),
    .ex_load        (ex_load),
    .ex_write_addr  (ex_write_addr),
    .mem_wr_en      (mem_wr_en),
    .mem_access     (mem_access),
    .mem_write_addr (mem_write_addr),
    .mem_ready      (mem_ready),
    .branch_taken   (branch_taken),
    .mem_req        (mem_req),
    .pc_en          (pc_en),
    .if_id_en       (if_id_en),
    .id_ex_en       (id_ex_en),
    .ex_mem_en      (ex_mem_en),
    .mem_wb_en      (mem_wb_en),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b),
    .mem_err        (mem_err)
`ifdef PIPE_STALL_CNT_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pipeline situation tracked as plain flags/counters: waiting on memory, how long,
  // whether the previous cycle was a load-use bubble, sticky error, total stalled cycles.
  bit m_waiting;
  int m_wait_len;
  bit m_after_bubble;
  bit m_err;
  int m_stalls;

  function automatic int exp_fwd(input logic [AW-1:0] rs);
    if (rs == 0) return 0;
    if (ex_wr_en && ex_write_addr == rs) return 1;
    if (mem_wr_en && mem_write_addr == rs) return 2;
    return 0;
  endfunction

  always @(negedge clk) begin
    bit req, pc, ifid, idex, exmem, memwb, fl_ifid, fl_idex;
    bit stall_now, hazard;
    int fa, fb;
    logic [12:0] got, exp;
    req = 0; pc = 1; ifid = 1; idex = 1; exmem = 1; memwb = 1; fl_ifid = 0; fl_idex = 0;
    fa = 0; fb = 0;
    stall_now = mem_access && !mem_ready;
    hazard = ex_load && ex_wr_en && ex_write_addr != 0 &&
             ((id_use_rs1 && id_rs1 == ex_write_addr) || (id_use_rs2 && id_rs2 == ex_write_addr));
    if (!rst) begin
      m_waiting = 0; m_wait_len = 0; m_after_bubble = 0; m_err = 0; m_stalls = 0;
    end else begin
      fa = exp_fwd(id_rs1);
      fb = exp_fwd(id_rs2);
      if (m_waiting) begin
        req = 1;
        {pc, ifid, idex, exmem, memwb} = {5{mem_ready}};
      end else if (stall_now) begin
        req = 1;
        {pc, ifid, idex, exmem, memwb} = 5'b0;
      end else if (!m_after_bubble && branch_taken) begin
        fl_ifid = 1; fl_idex = 1;
      end else if (!m_after_bubble && hazard) begin
        pc = 0; ifid = 0; fl_idex = 1;
      end
    end
    got = {mem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, fwd_a, fwd_b, mem_err};
    exp = {req, pc, ifid, idex, exmem, memwb, fl_ifid, fl_idex, 2'(fa), 2'(fb), m_err};
    chk("model_outputs", 32'(got), 32'(exp));
`ifdef PIPE_STALL_CNT_EN
    chk("model_stall_cnt", 32'(stall_cnt), 32'(m_stalls));
`endif
    if (rst) begin
      if (!pc && m_stalls < (2**CW - 1)) m_stalls++;
      if (m_waiting) begin
        if (mem_ready) m_waiting = 0;
        else m_wait_len++;
      end else if (stall_now) begin
        m_waiting = 1;
        m_wait_len = 1;
        m_after_bubble = 0;
      end else begin
        m_after_bubble = !m_after_bubble && !branch_taken && hazard;
      end
      if (m_waiting && m_wait_len >= TIMEOUT) m_err = 1;
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_wr_en = 0; ex_load = 0; ex_write_addr = '0;
    mem_wr_en = 0; mem_access = 0; mem_write_addr = '0;
    mem_ready = 0; branch_taken = 0;
  endtask

  initial begin
    n_vec = 0; n_bad = 0; cyc = 0;
    rst = 0;
    clear_inputs();
    mem_access = 1;
    branch_taken = 1;
    #3;
    chk("reset_mem_req", 32'(mem_req), 0);
    chk("reset_pc_en", 32'(pc_en), 1);
    chk("reset_flush", 32'({if_id_flush, id_ex_flush}), 0);
    chk("reset_mem_err", 32'(mem_err), 0);
    tick();
    tick();
    rst = 1;
    clear_inputs();
    tick();

    // load-use: one bubble, then result comes from MEM_WB
    ex_load = 1; ex_wr_en = 1; ex_write_addr = 3; id_rs1 = 3; id_use_rs1 = 1;
    #3;
    chk("lu_pc_en", 32'(pc_en), 0);
    chk("lu_if_id_en", 32'(if_id_en), 0);
    chk("lu_id_ex_flush", 32'(id_ex_flush), 1);
    tick();
    ex_load = 0; ex_wr_en = 0; ex_write_addr = 0; mem_wr_en = 1; mem_write_addr = 3;
    #3;
    chk("lu_after_en", 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 32'h1f);
    chk("lu_after_fwd_a", 32'(fwd_a), 2);
    tick();
    clear_inputs();
    tick();

    // branch flush overrides a simultaneous load-use
    branch_taken = 1; ex_load = 1; ex_wr_en = 1; ex_write_addr = 4; id_rs2 = 4; id_use_rs2 = 1;
    #3;
    chk("br_flushes", 32'({if_id_flush, id_ex_flush}), 32'h3);
    chk("br_pc_if_id_en", 32'({pc_en, if_id_en}), 32'h3);
    tick();
    clear_inputs();
    #3;
    chk("br_flush_one_cycle", 32'({if_id_flush, id_ex_flush}), 0);
    tick();

    // memory wait of 4 cycles
    mem_access = 1; mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #3;
      chk("mw_req_en", 32'({mem_req, pc_en, mem_wb_en}), 32'h4);
      tick();
    end
    mem_ready = 1;
    #3;
    chk("mw_ready_en", 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 32'h1f);
    chk("mw_no_err", 32'(mem_err), 0);
    tick();
    clear_inputs();
    #3;
    chk("mw_req_drop", 32'(mem_req), 0);
    tick();

    // timeout at 15 stall cycles, sticky
    mem_access = 1; mem_ready = 0; branch_taken = 1;
    for (int i = 0; i < 20; i++) begin
      #3;
      chk("to_err", 32'(mem_err), (i >= 15) ? 1 : 0);
      tick();
    end
    mem_ready = 1;
    tick();
    clear_inputs();
    #3;
    chk("to_err_sticky", 32'(mem_err), 1);
    chk("to_held_branch", 32'(if_id_flush), 0);
    tick();

    // forwarding priority
    ex_wr_en = 1; mem_wr_en = 1; ex_write_addr = 5; mem_write_addr = 5; id_rs2 = 5; id_rs1 = 6;
    #3;
    chk("fwd_b_exmem", 32'(fwd_b), 1);
    chk("fwd_a_none", 32'(fwd_a), 0);
    tick();
    ex_wr_en = 0;
    #3;
    chk("fwd_b_memwb", 32'(fwd_b), 2);
    tick();
    ex_wr_en = 1; ex_write_addr = 0; mem_write_addr = 0; id_rs2 = 0;
    #3;
    chk("fwd_b_r0", 32'(fwd_b), 0);
    tick();
    clear_inputs();

    // mixed traffic against the model
    for (int i = 0; i < 60; i++) begin
      id_rs1 = AW'($urandom_range(0, 7)); id_rs2 = AW'($urandom_range(0, 7));
      id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
      ex_wr_en = 1'($urandom); ex_load = ($urandom_range(0, 2) == 0);
      ex_write_addr = AW'($urandom_range(0, 7));
      mem_wr_en = 1'($urandom); mem_write_addr = AW'($urandom_range(0, 7));
      mem_access = ($urandom_range(0, 3) == 0); mem_ready = ($urandom_range(0, 2) != 0);
      branch_taken = ($urandom_range(0, 4) == 0);
      tick();
    end
    clear_inputs();
    tick();

    // async reset in the middle of a memory wait
    mem_access = 1; mem_ready = 0;
    tick();
    tick();
    #2;
    rst = 0;
    #1;
    chk("ar_mem_req", 32'(mem_req), 0);
    chk("ar_en", 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 32'h1f);
    chk("ar_mem_err", 32'(mem_err), 0);
`ifdef PIPE_STALL_CNT_EN
    chk("ar_stall_cnt", 32'(stall_cnt), 0);
`endif
    tick();
    rst = 1;
    clear_inputs();
    #3;
    chk("ar_after_release", 32'({mem_req, pc_en, mem_err}), 32'h2);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage 16-bit pipeline.
- Drives enable and flush for the IF_ID, ID_EX, EX_MEM and MEM_WB registers and the PC enable.
- Handles three hazards: load-use stalls, taken-branch flushes, and multicycle data-memory waits via a req/ready handshake.
- Also produces forwarding selects for the EX operand muxes.

Parameters:
- ADDR_W, 3, register-file address width.
- MEM_TIMEOUT, 15, maximum MEM_WAIT cycles before the error flag is raised.
- CNT_W, 16, stall-counter width (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  ADDR_W  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2.
- ex_wr_en, ex_load  in  1  EX instruction writes the RF / is a load (wb_mem_select).
- ex_write_addr  in  ADDR_W  EX destination.
- mem_wr_en, mem_access  in  1  MEM-stage instruction writes the RF / performs a load or store.
- mem_write_addr  in  ADDR_W  MEM destination.
- mem_ready  in  1  data memory completes the access this cycle.
- branch_taken  in  1  EX resolved a taken branch.
- mem_req  out  1  data-memory request, held until ready.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  register enables.
- if_id_flush, id_ex_flush  out  1  synchronous bubble insert (register loads zero).
- fwd_a, fwd_b  out  2  0 = RF, 1 = EX_MEM result, 2 = MEM_WB result.
- mem_err  out  1  sticky timeout flag.
- stall_cnt  out  CNT_W  total stall cycles (feature only).

Behaviour:
- Reset (rst=0, async):
  - State RUN.
  - All enables 1; flushes 0; mem_req 0; fwd 0; mem_err 0; timer 0; stall_cnt 0.
- FSM states: RUN, LOAD_STALL, MEM_WAIT. Registered state; outputs are combinational from state and inputs.
- RUN:
  - If mem_access=1 and mem_ready=0: assert mem_req, drop all enables, go to MEM_WAIT.
  - Else if branch_taken: if_id_flush=1, id_ex_flush=1, all enables 1, stay in RUN. The branch's own EX_MEM write proceeds.
  - Else if load-use hazard: pc_en=0, if_id_en=0, id_ex_flush=1, go to LOAD_STALL.
    - Load-use hazard = ex_load & ex_wr_en & ex_write_addr!=0 & ((id_use_rs1 & id_rs1==ex_write_addr) | (id_use_rs2 & id_rs2==ex_write_addr)).
  - Else: all enables 1.
  - If mem_access=1 and mem_ready=1 in the same cycle, the access completes with no stall.
- LOAD_STALL: lasts exactly 1 cycle. All enables 1, return to RUN; the load result is now forwarded from MEM_WB.
- MEM_WAIT:
  - mem_req=1; all five enables 0; flushes 0.
  - The timer increments each cycle.
  - On mem_ready=1: enables return to 1 in that same cycle; go to RUN; timer clears.
  - On timer==MEM_TIMEOUT: set mem_err; the FSM stays in MEM_WAIT until ready.
- Priority in RUN: memory wait > branch flush > load-use.
  - A branch_taken arriving during MEM_WAIT is held by the frozen EX_MEM and acted on after the wait.
- Forwarding (combinational), per operand:
  - EX_MEM match (ex_wr_en, addr!=0, equal) has priority → 1.
  - Else MEM_WB match → 2.
  - Else 0.
  - Register 0 never forwards.
- Reset asserted mid-MEM_WAIT: immediately return to RUN and drop mem_req; no handshake completion is required.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- Defined: stall_cnt increments on every cycle with pc_en=0, saturating at all-ones; it is cleared only by reset.
- Undefined: the stall_cnt port is absent and no counter logic is built.

Decomposition:
- Shared package pipe_pkg holds:
  - state enum {RUN, LOAD_STALL, MEM_WAIT};
  - forwarding-select constants FWD_RF=0, FWD_EXMEM=1, FWD_MEMWB=2;
  - ADDR_W.
- One natural sub-module, pipe_fwd_unit: the purely combinational forwarding compare, instantiated once per operand.

Test Plan:
- Load-use stall:
  - Stimulus: ex_load=1, ex_wr_en=1, ex_write_addr=3, id_rs1=3, id_use_rs1=1.
  - Cycle 0: pc_en=0, if_id_en=0, id_ex_flush=1.
  - Cycle 1: all enables 1, state back to RUN.
- Branch flush:
  - Stimulus: branch_taken=1.
  - Response: if_id_flush=id_ex_flush=1 for one cycle, pc_en=1; a simultaneous load-use condition is ignored.
- Memory wait:
  - Stimulus: mem_access=1, mem_ready held 0 for 4 cycles.
  - Response: mem_req=1 and all enables 0 for 4 cycles; enables return to 1 in the ready cycle; mem_err stays 0.
- Timeout:
  - Stimulus: mem_ready held 0 for 20 cycles.
  - Response: mem_err=1 from cycle 15 onward; it stays 1 after ready and clears only on rst=0.
- Forwarding priority:
  - Stimulus: ex_write_addr=mem_write_addr=5, both wr_en=1, id_rs2=5.
  - Response: fwd_b=1. With address 0 instead: fwd_b=0.
- Async reset:
  - Stimulus: rst low mid-MEM_WAIT, between clock edges.
  - Response: mem_req=0 and enables=1 without waiting for a clock edge; with PIPE_STALL_CNT_EN, stall_cnt=0.
